// File: rtl/fb_read_arbiter.sv
// fb_read_arbiter
//   Shares the single synchronous read port of the "current" framebuffer between the
//   driver (shift-out, timing critical) and the animator (read-modify-write). The driver
//   has fixed priority. The animator is protected by a starvation counter that flips
//   priority after c_max_wait consecutive denied cycles. In-flight reads carry an owner
//   tag, so each return goes only to the requester that issued it.
//
// Ports
//   i_clk, i_rst                  clock, asynchronous active-high reset
//   i_drv_req / i_drv_addr        driver request and address (held until o_drv_gnt)
//   o_drv_gnt                     driver accepted this cycle (combinational)
//   o_drv_valid / o_drv_data      one-cycle return pulse / registered return data
//   i_ani_req / i_ani_addr        animator request and address (held until o_ani_gnt)
//   o_ani_gnt                     animator accepted this cycle (combinational)
//   o_ani_valid / o_ani_data      one-cycle return pulse / registered return data
//   o_fb_raddr                    framebuffer read address
//   i_fb_rdata                    framebuffer read data, c_rd_lat cycles after the address
module fb_read_arbiter #(
    parameter int unsigned c_ledboards = 2,
    parameter int unsigned c_bpc       = 12,
    parameter int unsigned c_rd_lat    = 1,
    parameter int unsigned c_max_wait  = 8,
    localparam int unsigned c_addr_w   = $clog2(c_ledboards * 32)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_drv_req,
    input  logic [c_addr_w-1:0] i_drv_addr,
    output logic                o_drv_gnt,
    output logic                o_drv_valid,
    output logic [c_bpc-1:0]    o_drv_data,
    input  logic                i_ani_req,
    input  logic [c_addr_w-1:0] i_ani_addr,
    output logic                o_ani_gnt,
    output logic                o_ani_valid,
    output logic [c_bpc-1:0]    o_ani_data,
    output logic [c_addr_w-1:0] o_fb_raddr,
    input  logic [c_bpc-1:0]    i_fb_rdata
);

    localparam int unsigned c_cnt_w = $clog2(c_max_wait + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(c_max_wait);

    typedef enum logic {DrvPrio, AniPrio} prio_e;

    prio_e               prio_q, prio_d;
    logic [c_cnt_w-1:0]  wait_q, wait_d;
    logic [c_addr_w-1:0] raddr_q;
    logic [c_rd_lat-1:0] tag_vld_q;
    logic [c_rd_lat-1:0] tag_ani_q;
    logic                drv_valid_q, ani_valid_q;
    logic [c_bpc-1:0]    drv_data_q, ani_data_q;

    logic                drv_gnt, ani_gnt, any_gnt;
    logic [c_addr_w-1:0] gnt_addr;
    logic                ret_vld, ret_ani;

    // Grants are gated by reset so nothing is accepted while the pipeline is being cleared.
    always_comb begin
        drv_gnt = 1'b0;
        ani_gnt = 1'b0;
        if (!i_rst) begin
            case (prio_q)
                DrvPrio: begin
                    if (i_drv_req)      drv_gnt = 1'b1;
                    else if (i_ani_req) ani_gnt = 1'b1;
                end
                AniPrio: begin
                    if (i_ani_req)      ani_gnt = 1'b1;
                    else if (i_drv_req) drv_gnt = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign any_gnt  = drv_gnt | ani_gnt;
    assign gnt_addr = ani_gnt ? i_ani_addr : i_drv_addr;

    // Starvation counter and priority next state. Priority flips to the animator on the
    // cycle the counter reaches its limit, and returns to the driver after any animator grant.
    always_comb begin
        wait_d = wait_q;
        prio_d = prio_q;
        if (ani_gnt) begin
            wait_d = '0;
        end else if (i_ani_req && (wait_q != c_cnt_max)) begin
            wait_d = wait_q + c_cnt_w'(1);
        end
        if (ani_gnt) begin
            prio_d = DrvPrio;
        end else if (wait_d == c_cnt_max) begin
            prio_d = AniPrio;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            prio_q  <= DrvPrio;
            wait_q  <= '0;
            raddr_q <= '0;
        end else begin
            prio_q <= prio_d;
            wait_q <= wait_d;
            if (any_gnt) raddr_q <= gnt_addr;
        end
    end

    // Hold the last granted address when idle so the framebuffer sees no spurious change.
    assign o_fb_raddr = any_gnt ? gnt_addr : raddr_q;

    // Tag pipeline: one {valid, owner} stage per cycle of framebuffer read latency.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tag_vld_q <= '0;
            tag_ani_q <= '0;
        end else begin
            tag_vld_q[0] <= any_gnt;
            tag_ani_q[0] <= ani_gnt;
            for (int i = 1; i < int'(c_rd_lat); i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_ani_q[i] <= tag_ani_q[i-1];
            end
        end
    end

    assign ret_vld = tag_vld_q[c_rd_lat-1];
    assign ret_ani = tag_ani_q[c_rd_lat-1];

    // Return routing: only the owner's data register and valid are touched.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            drv_valid_q <= 1'b0;
            ani_valid_q <= 1'b0;
            drv_data_q  <= '0;
            ani_data_q  <= '0;
        end else begin
            drv_valid_q <= ret_vld && !ret_ani;
            ani_valid_q <= ret_vld && ret_ani;
            if (ret_vld && !ret_ani) drv_data_q <= i_fb_rdata;
            if (ret_vld && ret_ani)  ani_data_q <= i_fb_rdata;
        end
    end

    assign o_drv_gnt   = drv_gnt;
    assign o_ani_gnt   = ani_gnt;
    assign o_drv_valid = drv_valid_q;
    assign o_drv_data  = drv_data_q;
    assign o_ani_valid = ani_valid_q;
    assign o_ani_data  = ani_data_q;

endmodule

// File: tb/tb_fb_read_arbiter.sv
// Directed bench for fb_read_arbiter. Two instances share the same request stimulus:
// index 0 uses c_rd_lat=1, index 1 uses c_rd_lat=3. Each has its own framebuffer model
// returning addr*3. Expected grants are written per step; expected returns are scheduled
// at grant cycle + latency + 1 for each instance.
module tb_fb_read_arbiter;

    localparam int unsigned AW    = 6;
    localparam int unsigned BPC   = 12;
    localparam int unsigned DEPTH = 512;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          drv_req = 1'b0;
    logic          ani_req = 1'b0;
    logic [AW-1:0] drv_addr = '0;
    logic [AW-1:0] ani_addr = '0;

    logic           d_gnt [2];
    logic           d_val [2];
    logic [BPC-1:0] d_dat [2];
    logic           a_gnt [2];
    logic           a_val [2];
    logic [BPC-1:0] a_dat [2];
    logic [AW-1:0]  raddr [2];
    logic [BPC-1:0] rdata [2];

    fb_read_arbiter #(
        .c_ledboards(2), .c_bpc(BPC), .c_rd_lat(1), .c_max_wait(8)
    ) dut1 (
        .i_clk(clk), .i_rst(rst),
        .i_drv_req(drv_req), .i_drv_addr(drv_addr), .o_drv_gnt(d_gnt[0]),
        .o_drv_valid(d_val[0]), .o_drv_data(d_dat[0]),
        .i_ani_req(ani_req), .i_ani_addr(ani_addr), .o_ani_gnt(a_gnt[0]),
        .o_ani_valid(a_val[0]), .o_ani_data(a_dat[0]),
        .o_fb_raddr(raddr[0]), .i_fb_rdata(rdata[0])
    );

    fb_read_arbiter #(
        .c_ledboards(2), .c_bpc(BPC), .c_rd_lat(3), .c_max_wait(8)
    ) dut3 (
        .i_clk(clk), .i_rst(rst),
        .i_drv_req(drv_req), .i_drv_addr(drv_addr), .o_drv_gnt(d_gnt[1]),
        .o_drv_valid(d_val[1]), .o_drv_data(d_dat[1]),
        .i_ani_req(ani_req), .i_ani_addr(ani_addr), .o_ani_gnt(a_gnt[1]),
        .o_ani_valid(a_val[1]), .o_ani_data(a_dat[1]),
        .o_fb_raddr(raddr[1]), .i_fb_rdata(rdata[1])
    );

    // Framebuffer models: content at address a is a*3.
    logic [BPC-1:0] fb1_q;
    logic [BPC-1:0] fb3_q [3];
    always_ff @(posedge clk) begin
        fb1_q    <= BPC'(raddr[0] * 3);
        fb3_q[0] <= BPC'(raddr[1] * 3);
        fb3_q[1] <= fb3_q[0];
        fb3_q[2] <= fb3_q[1];
    end
    assign rdata[0] = fb1_q;
    assign rdata[1] = fb3_q[2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [AW-1:0] last_addr = '0;

    // Expected returns, indexed [instance*2 + owner][cycle]; owner 0=driver, 1=animator.
    bit             ev [4][DEPTH];
    logic [BPC-1:0] ed [4][DEPTH];

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic clear_exp();
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < int'(DEPTH); j++) begin
                ev[k][j] = 1'b0;
                ed[k][j] = '0;
            end
        end
    endtask

    task automatic chk(input string tag, input int d, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s lat%0d cyc=%0d: got %0h expected %0h",
                   tag, lat_of(d), cyc, obs, exp);
        end
    endtask

    // One clock cycle: drive requests, check at the falling edge, schedule returns.
    task automatic do_cycle(input logic dreq, input logic [AW-1:0] daddr,
                            input logic areq, input logic [AW-1:0] aaddr,
                            input bit exp_dg, input bit exp_ag);
        drv_req  = dreq;
        drv_addr = daddr;
        ani_req  = areq;
        ani_addr = aaddr;
        @(negedge clk);
        if (exp_dg)      last_addr = daddr;
        else if (exp_ag) last_addr = aaddr;
        for (int d = 0; d < 2; d++) begin
            chk("drv_gnt", d, 32'(d_gnt[d]), 32'(exp_dg));
            chk("ani_gnt", d, 32'(a_gnt[d]), 32'(exp_ag));
            chk("fb_raddr", d, 32'(raddr[d]), 32'(last_addr));
            chk("drv_valid", d, 32'(d_val[d]), 32'(ev[d*2][cyc]));
            chk("ani_valid", d, 32'(a_val[d]), 32'(ev[d*2+1][cyc]));
            if (ev[d*2][cyc])   chk("drv_data", d, 32'(d_dat[d]), 32'(ed[d*2][cyc]));
            if (ev[d*2+1][cyc]) chk("ani_data", d, 32'(a_dat[d]), 32'(ed[d*2+1][cyc]));
            if (exp_dg) begin
                ev[d*2][cyc+lat_of(d)+1] = 1'b1;
                ed[d*2][cyc+lat_of(d)+1] = BPC'(daddr * 3);
            end
            if (exp_ag) begin
                ev[d*2+1][cyc+lat_of(d)+1] = 1'b1;
                ed[d*2+1][cyc+lat_of(d)+1] = BPC'(aaddr * 3);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_reset_outputs();
        for (int d = 0; d < 2; d++) begin
            chk("rst_drv_gnt", d, 32'(d_gnt[d]), 32'd0);
            chk("rst_ani_gnt", d, 32'(a_gnt[d]), 32'd0);
            chk("rst_drv_valid", d, 32'(d_val[d]), 32'd0);
            chk("rst_ani_valid", d, 32'(a_val[d]), 32'd0);
            chk("rst_drv_data", d, 32'(d_dat[d]), 32'd0);
            chk("rst_ani_data", d, 32'(a_dat[d]), 32'd0);
            chk("rst_fb_raddr", d, 32'(raddr[d]), 32'd0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        clear_exp();
        // Power-on reset with a pending driver request: no grant may appear during reset.
        drv_req  = 1'b1;
        drv_addr = 6'd9;
        @(negedge clk);
        chk_reset_outputs();
        @(posedge clk);
        #1;
        drv_req = 1'b0;
        rst     = 1'b0;

        // Test 1: reset mid-read discards the in-flight return.
        do_cycle(1'b1, 6'd5, 1'b0, '0, 1'b1, 1'b0);
        rst      = 1'b1;
        drv_req  = 1'b1;
        drv_addr = 6'd5;
        @(negedge clk);
        chk_reset_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
        clear_exp();
        last_addr = '0;
        idle(6);

        // Test 2: driver only, 64 back-to-back reads.
        for (int i = 0; i < 64; i++) do_cycle(1'b1, AW'(i), 1'b0, '0, 1'b1, 1'b0);
        idle(5);

        // Test 3: single animator read of address 17 returns 51.
        do_cycle(1'b0, '0, 1'b1, 6'd17, 1'b0, 1'b1);
        idle(5);

        // Test 5: simultaneous first request; animator wins once the driver drops.
        for (int i = 0; i < 3; i++) do_cycle(1'b1, AW'(10 + i), 1'b1, 6'd40, 1'b1, 1'b0);
        do_cycle(1'b0, '0, 1'b1, 6'd40, 1'b0, 1'b1);
        idle(5);

        // Test 4/6: continuous contention from a cleared counter -> 8 driver, 1 animator.
        for (int c = 0; c < 27; c++) begin
            do_cycle(1'b1, AW'(c % 32), 1'b1, AW'(32 + (c % 32)),
                     (c % 9) < 8, (c % 9) == 8);
        end
        idle(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
